// File: rtl/dct_quant_pkg.sv
// Shared constants for the quantization / zigzag stage: block geometry,
// the JPEG luminance quantizer, its rounded reciprocals and the zigzag map.
package dct_quant_pkg;

    localparam int BLK_N   = 64;
    localparam int ADDR_W  = 6;
    localparam int FRAC_W  = 16;
    localparam int RECIP_W = 16;
    localparam int RND     = 1 << (FRAC_W - 1);

    typedef enum logic {
        RD_IDLE,
        RD_RUN
    } rd_state_t;

    // Standard JPEG luminance quantizer, raster order (row u, column v).
    localparam int unsigned Q_LUMA [BLK_N] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    // round(65536 / Q_LUMA[i]); lets the quantizer multiply instead of divide.
    localparam logic [RECIP_W-1:0] RECIP [BLK_N] = '{
        16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
        16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
        16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170,
        16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057,
        16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851,
        16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712,
        16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649,
        16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662
    };

    // Zigzag position -> raster index.
    localparam logic [ADDR_W-1:0] ZZ [BLK_N] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/dct_pp_buf.sv
// Two-bank block buffer: one bank fills while the other is read out.
// Contents are never reset; the write-side bookkeeping decides what is valid.
module dct_pp_buf
    import dct_quant_pkg::*;
#(
    parameter int BWq = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wbank,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BWq-1:0]    wdata,
    input  logic              rbank,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BWq-1:0]    rdata
);

    logic [BWq-1:0] mem [2*BLK_N];

    // Write port: bank bit on top of the coefficient address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wbank, waddr}] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata <= mem[{rbank, raddr}];
    end

endmodule

// File: rtl/dct_quant_zz.sv
// Quantizes raster-order DCT coefficients with reciprocal multiplication,
// buffers each 8x8 block and replays it in zigzag order.
module dct_quant_zz
    import dct_quant_pkg::*;
#(
    parameter int BWi = 12,
    parameter int BWq = 12,
    parameter int BWr = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enb,
    input  logic [BWi-1:0] coef_in,
    output logic [BWq-1:0] q_out,
    output logic           q_vld,
    output logic           q_sob,
    output logic           q_eob,
    output logic           ovf
);

    localparam int PW = BWi + BWr;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_N - 1);

    logic [ADDR_W-1:0] wi;
    logic [BWi-1:0]    coef_abs;
    logic              s1_vld;
    logic              s1_sign;
    logic [ADDR_W-1:0] s1_wi;
    logic [PW-1:0]     s1_prod;
    logic [BWq-1:0]    s1_mag;
    logic              s2_vld;
    logic [ADDR_W-1:0] s2_wi;
    logic [BWq-1:0]    s2_q;
    logic              wbank;
    logic              blk_done;

    rd_state_t         rd_state, rd_state_nxt;
    logic [ADDR_W-1:0] rc, rc_nxt;
    logic              rd_bank, rd_bank_nxt;
    logic              rd_pend, rd_pend_nxt;
    logic              pend_bank, pend_bank_nxt;
    logic              ovf_nxt;
    logic              rd_last;
    logic [BWq-1:0]    rdata;
    logic              rd_vld;
    logic              rd_sob;
    logic              rd_eob;

    // Magnitude of the input and rounded magnitude of the stage-1 product.
    always_comb begin
        coef_abs = coef_in[BWi-1] ? -coef_in : coef_in;
        s1_mag   = BWq'((s1_prod + PW'(RND)) >> FRAC_W);
    end

    // Stage 1: multiply |coef| by the reciprocal for its raster slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wi      <= '0;
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_wi   <= '0;
            s1_prod <= '0;
        end else begin
            s1_vld <= enb;
            if (enb) begin
                s1_prod <= PW'(coef_abs) * PW'(RECIP[wi]);
                s1_sign <= coef_in[BWi-1];
                s1_wi   <= wi;
                wi      <= wi + 1'b1;
            end
        end
    end

    // Stage 2: restore the sign; the result feeds the buffer write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_wi  <= '0;
            s2_q   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_wi <= s1_wi;
                s2_q  <= s1_sign ? -s1_mag : s1_mag;
            end
        end
    end

    assign blk_done = s2_vld && (s2_wi == LAST_IDX);

    // Write bank flips as the last coefficient of a block lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
        end else if (blk_done) begin
            wbank <= ~wbank;
        end
    end

    dct_pp_buf #(.BWq(BWq)) u_buf (
        .clk   (clk),
        .we    (s2_vld),
        .wbank (wbank),
        .waddr (s2_wi),
        .wdata (s2_q),
        .rbank (rd_bank),
        .raddr (ZZ[rc]),
        .rdata (rdata)
    );

    // Reader state, zigzag counter, pending request and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= RD_IDLE;
            rc        <= '0;
            rd_bank   <= 1'b0;
            rd_pend   <= 1'b0;
            pend_bank <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            rd_state  <= rd_state_nxt;
            rc        <= rc_nxt;
            rd_bank   <= rd_bank_nxt;
            rd_pend   <= rd_pend_nxt;
            pend_bank <= pend_bank_nxt;
            ovf       <= ovf_nxt;
        end
    end

    // A finishing read chains straight into a pending or just-completed
    // block, so back-to-back blocks leave no bubble on the output.
    always_comb begin
        rd_state_nxt  = rd_state;
        rc_nxt        = rc;
        rd_bank_nxt   = rd_bank;
        rd_pend_nxt   = rd_pend;
        pend_bank_nxt = pend_bank;
        ovf_nxt       = ovf;
        rd_last       = (rd_state == RD_RUN) && (rc == LAST_IDX);
        case (rd_state)
            RD_IDLE: begin
                if (rd_pend) begin
                    rd_state_nxt  = RD_RUN;
                    rc_nxt        = '0;
                    rd_bank_nxt   = pend_bank;
                    rd_pend_nxt   = blk_done;
                    pend_bank_nxt = wbank;
                end else if (blk_done) begin
                    rd_state_nxt = RD_RUN;
                    rc_nxt       = '0;
                    rd_bank_nxt  = wbank;
                end
            end
            RD_RUN: begin
                if (rd_last) begin
                    rc_nxt = '0;
                    if (rd_pend) begin
                        rd_bank_nxt   = pend_bank;
                        rd_pend_nxt   = blk_done;
                        pend_bank_nxt = wbank;
                    end else if (blk_done) begin
                        rd_bank_nxt = wbank;
                    end else begin
                        rd_state_nxt = RD_IDLE;
                    end
                end else begin
                    rc_nxt = rc + 1'b1;
                    if (blk_done) begin
                        if (rd_pend) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            rd_pend_nxt   = 1'b1;
                            pend_bank_nxt = wbank;
                        end
                    end
                end
            end
            default: begin
                rd_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Output pipeline: flags travel with the registered RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_sob <= 1'b0;
            rd_eob <= 1'b0;
            q_vld  <= 1'b0;
            q_sob  <= 1'b0;
            q_eob  <= 1'b0;
            q_out  <= '0;
        end else begin
            rd_vld <= (rd_state == RD_RUN);
            rd_sob <= (rd_state == RD_RUN) && (rc == '0);
            rd_eob <= rd_last;
            q_vld  <= rd_vld;
            q_sob  <= rd_sob;
            q_eob  <= rd_eob;
            q_out  <= rd_vld ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_dct_quant_zz.sv
// Directed bench for dct_quant_zz: hand-checked blocks, random streaming
// against an independent quantize/zigzag model, mid-block reset, overflow.
module tb_dct_quant_zz;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enb = 1'b0;
    logic [11:0] coef_in = '0;
    logic [11:0] q_out;
    logic        q_vld;
    logic        q_sob;
    logic        q_eob;
    logic        ovf;

    dct_quant_zz #(.BWi(12), .BWq(12), .BWr(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enb     (enb),
        .coef_in (coef_in),
        .q_out   (q_out),
        .q_vld   (q_vld),
        .q_sob   (q_sob),
        .q_eob   (q_eob),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int edge_n = 0;
    int last_edge = 0;
    int rd_ptr = 0;
    int out_val[$];
    int out_sob[$];
    int out_eob[$];
    int out_edge[$];
    int exp_val[$];
    int stim[64];
    int zz_tb[64];
    int q_tab[64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    // Rising-edge counter used to measure latency and output contiguity.
    always @(posedge clk) edge_n <= edge_n + 1;

    // Capture every valid output away from the active edge.
    always @(negedge clk) begin
        if (q_vld) begin
            out_val.push_back(int'($signed(q_out)));
            out_sob.push_back(int'(q_sob));
            out_eob.push_back(int'(q_eob));
            out_edge.push_back(edge_n);
        end
    end

    // Hard stop in case something upstream stalls forever.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int c, input int r);
        int rcp;
        int a;
        int m;
        rcp = (65536 + q_tab[r] / 2) / q_tab[r];
        a = (c < 0) ? -c : c;
        m = (a * rcp + 32768) / 65536;
        return (c < 0) ? -m : m;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) stim[i] = 0;
    endtask

    task automatic random_stim();
        for (int i = 0; i < 64; i++) stim[i] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic load_block();
        for (int k = 0; k < 64; k++) exp_val.push_back(model(stim[zz_tb[k]], zz_tb[k]));
    endtask

    task automatic applyStimulus(input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < 64 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                enb = 1'b0;
                coef_in = 12'hABC;
            end else begin
                enb = 1'b1;
                coef_in = 12'(stim[i]);
                i++;
            end
        end
    endtask

    task automatic idle_input();
        @(negedge clk);
        enb = 1'b0;
        coef_in = '0;
        last_edge = edge_n;
    endtask

    task automatic wait_outputs(input int n, input string tag);
        int budget = 400;
        while (out_val.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, out_val.size(), (out_val.size() >= n) ? out_val.size() : n);
    endtask

    task automatic check_blocks(input int nb, input bit contig, input string tag);
        int base = rd_ptr;
        for (int k = 0; k < nb * 64; k++) begin
            int e = exp_val.pop_front();
            int bb = base + (k / 64) * 64;
            checkOutput($sformatf("%s_val[%0d]", tag, k), out_val[base + k], e);
            checkOutput($sformatf("%s_sob[%0d]", tag, k), out_sob[base + k], (k % 64 == 0) ? 1 : 0);
            checkOutput($sformatf("%s_eob[%0d]", tag, k), out_eob[base + k], (k % 64 == 63) ? 1 : 0);
            if (contig)
                checkOutput($sformatf("%s_gap[%0d]", tag, k), out_edge[base + k] - out_edge[base], k);
            else
                checkOutput($sformatf("%s_gap[%0d]", tag, k), out_edge[base + k] - out_edge[bb], k % 64);
        end
        rd_ptr = base + nb * 64;
    endtask

    initial begin
        int idx;
        int sz;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            for (int d = (s < 8) ? s : 7; d >= 0 && s - d < 8; d--) begin
                zz_tb[idx] = (s % 2 == 0) ? (d * 8 + (s - d)) : ((s - d) * 8 + d);
                idx++;
            end
        end

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_q_out", int'(q_out), 0);
        checkOutput("rst_q_vld", int'(q_vld), 0);
        checkOutput("rst_q_sob", int'(q_sob), 0);
        checkOutput("rst_q_eob", int'(q_eob), 0);
        checkOutput("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero block, latency from last input to first output.
        clear_stim();
        load_block();
        applyStimulus(1'b0);
        idle_input();
        wait_outputs(rd_ptr + 64, "t1_wait");
        checkOutput("t1_latency", out_edge[rd_ptr] - last_edge, 4);
        check_blocks(1, 1'b1, "t1");
        checkOutput("t1_ovf", int'(ovf), 0);

        // DC only: 160 / 16 = 10.
        clear_stim();
        stim[0] = 160;
        load_block();
        applyStimulus(1'b0);
        idle_input();
        wait_outputs(rd_ptr + 64, "t2_wait");
        checkOutput("t2_dc_hand", out_val[rd_ptr], 10);
        check_blocks(1, 1'b1, "t2");

        // Rounding at the DC slot: -8 -> -1, 7 -> 0, 8 -> 1.
        clear_stim();
        stim[0] = -8;
        load_block();
        applyStimulus(1'b0);
        idle_input();
        wait_outputs(rd_ptr + 64, "t3a_wait");
        checkOutput("t3a_hand", out_val[rd_ptr], -1);
        check_blocks(1, 1'b1, "t3a");
        stim[0] = 7;
        load_block();
        applyStimulus(1'b0);
        idle_input();
        wait_outputs(rd_ptr + 64, "t3b_wait");
        checkOutput("t3b_hand", out_val[rd_ptr], 0);
        check_blocks(1, 1'b1, "t3b");
        stim[0] = 8;
        load_block();
        applyStimulus(1'b0);
        idle_input();
        wait_outputs(rd_ptr + 64, "t3c_wait");
        checkOutput("t3c_hand", out_val[rd_ptr], 1);
        check_blocks(1, 1'b1, "t3c");

        // Zigzag placement: raster 8 lands at output position 2.
        clear_stim();
        stim[8] = 120;
        load_block();
        applyStimulus(1'b0);
        idle_input();
        wait_outputs(rd_ptr + 64, "t4_wait");
        checkOutput("t4_pos2_hand", out_val[rd_ptr + 2], 10);
        checkOutput("t4_pos1_hand", out_val[rd_ptr + 1], 0);
        check_blocks(1, 1'b1, "t4");

        // Three random blocks back-to-back: 192 contiguous outputs.
        for (int b = 0; b < 3; b++) begin
            random_stim();
            load_block();
            applyStimulus(1'b0);
        end
        idle_input();
        wait_outputs(rd_ptr + 192, "t5_wait");
        check_blocks(3, 1'b1, "t5");
        checkOutput("t5_ovf", int'(ovf), 0);

        // Same with random input gaps.
        for (int b = 0; b < 3; b++) begin
            random_stim();
            load_block();
            applyStimulus(1'b1);
        end
        idle_input();
        wait_outputs(rd_ptr + 192, "t5g_wait");
        check_blocks(3, 1'b0, "t5g");
        checkOutput("t5g_ovf", int'(ovf), 0);

        // Reset after 30 inputs: partial block must vanish.
        repeat (5) @(negedge clk);
        random_stim();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            enb = 1'b1;
            coef_in = 12'(stim[i]);
        end
        @(negedge clk);
        enb = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t6_rst_vld", int'(q_vld), 0);
        checkOutput("t6_rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        sz = out_val.size();
        checkOutput("t6_no_stray", sz, rd_ptr);
        random_stim();
        load_block();
        applyStimulus(1'b0);
        idle_input();
        wait_outputs(sz + 64, "t6_wait");
        repeat (80) @(negedge clk);
        checkOutput("t6_count", out_val.size() - sz, 64);
        rd_ptr = sz;
        check_blocks(1, 1'b1, "t6");

        // Overflow: block completes while reading with a request pending.
        checkOutput("t7_ovf_pre", int'(ovf), 0);
        random_stim();
        applyStimulus(1'b0);
        idle_input();
        repeat (10) @(negedge clk);
        force dut.rd_pend = 1'b1;
        applyStimulus(1'b0);
        idle_input();
        repeat (4) @(negedge clk);
        release dut.rd_pend;
        checkOutput("t7_ovf_set", int'(ovf), 1);
        repeat (200) @(negedge clk);
        checkOutput("t7_ovf_sticky", int'(ovf), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_quant_zz.md
Name: dct_quant_zz

Overview:
Quantization and zigzag reorder stage. It sits directly downstream of dct_top and consumes its 12-bit 2D-DCT coefficient stream, 64 per 8x8 block in raster order. Each coefficient is quantized against the standard JPEG luminance table using reciprocal multiplication. Each block is buffered in a ping-pong RAM and re-emitted in zigzag order for the entropy coder.

Parameters:
BWi, 12, input coefficient width (signed, two's complement)
BWq, 12, quantized output width (signed)
BWr, 16, reciprocal table entry width (unsigned)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
enb  input  1  coefficient valid strobe; one coefficient per high cycle
coef_in  input  BWi  signed DCT coefficient, raster index u*8+v
q_out  output  BWq  quantized coefficient, zigzag order
q_vld  output  1  q_out valid
q_sob  output  1  high with first coefficient (DC) of a block
q_eob  output  1  high with 64th coefficient of a block
ovf  output  1  sticky overflow error

Behaviour:
- Reset (async, rst_n low): q_out=0, q_vld=0, q_sob=0, q_eob=0, ovf=0. Write index, bank select, pending/busy flags and read counter all clear. Buffer contents are don't-care.
- Write index wi (6 bit) counts accepted coefficients and wraps 63->0. Gaps in enb are legal; wi holds.
- Stage 1 (registered): prod = |coef_in| * RECIP[wi]. RECIP[i] = round(65536/Q[i]), 24-bit unsigned product. Sign and wi are piped alongside.
- Stage 2 (registered): mag = (prod + 2^15) >> 16, i.e. round half away from zero. Result = sign ? -mag : mag, sign-extended to BWq. It is written to wbank[wi_d2].
- Block full when the entry with wi_d2=63 is written. On that cycle the write bank toggles and a read request is raised for the filled bank.
- Reader: IDLE -> RUN on request. In RUN it issues rc=0..63, reading rbank[ZZ[rc]]. q_out/q_vld are registered from the RAM read.
  - q_sob is high when rc=0 is output.
  - q_eob is high when rc=63 is output.
  - RUN -> IDLE after rc=63, unless a request is pending, in which case it goes straight to RUN on the other bank with no bubble.
- Latency: 64th input at cycle t -> first zigzag output (q_sob) at t+4. Output is 64 contiguous q_vld cycles.
- Continuous streaming (enb always high) must sustain indefinitely with no output gaps after the first block and ovf=0.
- Overflow: a block completes while the reader is busy and a request is already pending -> ovf sets and stays set until reset. The new block still overwrites its bank (data loss accepted).
- Simultaneous block-complete and reader finishing rc=63 is not overflow. The request is taken as the next RUN.
- Reset mid-block discards the partial block; no outputs are produced for it.
- Saturation: with Q>=10 the |result| is <=205, so no clipping is needed. A BWq narrower than 9 is illegal.

Decomposition:
- Package dct_quant_pkg holds:
  - Q_LUMA[64], the standard JPEG luminance table in raster order.
  - RECIP[64], precomputed 16-bit reciprocals.
  - ZZ[64], zigzag-to-raster index map (0,1,8,16,9,2,3,10,...).
  - Constants BLK_N=64 and RND=2^15.
- One sub-module: dct_pp_buf, a 2x64xBWq ping-pong RAM with independent write port (bank, addr) and registered read port (bank, addr).

Test Plan:
1. All-zero block, enb high 64 cycles -> 64 outputs of 0; q_sob on output 0, q_eob on output 63, ovf=0, first output 4 cycles after last input.
2. DC test: raster 0 = 160 (Q=16, RECIP=4096), rest 0 -> first output 10, remaining 63 outputs 0.
3. Rounding at raster 0:
   - coef -8 -> -1
   - coef 7 -> 0
   - coef 8 -> 1
   Other coefficients 0.
4. Zigzag placement: raster 8 = 120 (Q=12, RECIP=5461), rest 0 -> output position 2 is 10, all others 0.
5. Streaming: 3 blocks back-to-back, enb high 192 cycles with random values -> 192 contiguous q_vld cycles, each value matches the golden model, ovf=0. Repeat with random enb gaps -> same values, ovf=0.
6. Reset mid-block: drop rst_n after 30 inputs, release, send one full block -> exactly 64 outputs, all from the new block. Forcing a third completed block while the reader is busy and a request is pending -> ovf=1 and stays 1.
